// File: rtl/locked_reg_programmer.sv
// rtl/locked_reg_programmer.sv - write/readback/lock sequencer for a bank of lockable config registers
module locked_reg_programmer #(
  parameter int DATA_W        = 16,
  parameter int NUM_REGS      = 4,
  parameter int ADDR_W        = 2,
  parameter int READBACK_WAIT = 1
) (
  input  logic                       Clk,
  input  logic                       resetn,
  input  logic                       scan_mode,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       req_lock,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [NUM_REGS-1:0]        reg_write,
  output logic [DATA_W-1:0]          reg_data_in,
  output logic [NUM_REGS-1:0]        reg_lock,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_out,
  output logic [NUM_REGS-1:0]        lock_shadow
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT, S_CHECK, S_LOCK, S_RESP
  } state_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_LOCKED   = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_SCAN     = 2'b11;

  state_t                state, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic                  lock_q;
  logic [3:0]            cnt_q;
  logic [1:0]            status_q, status_d;
  logic [NUM_REGS-1:0]   shadow_q;
  logic [NUM_REGS-1:0]   addr_onehot;
  logic [DATA_W-1:0]     readback;

  assign addr_onehot = NUM_REGS'(1) << addr_q;
  assign reg_data_in = data_q;
  assign rsp_status  = status_q;
  assign lock_shadow = shadow_q;

  always_comb begin
    readback = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) readback = reg_data_out[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  // scan_mode aborts any in-flight operation before it can strobe or lock
  always_comb begin
    state_d  = state;
    status_d = status_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (scan_mode) begin
            state_d  = S_RESP;
            status_d = ST_SCAN;
          end else if (shadow_q[req_addr]) begin
            state_d  = S_RESP;
            status_d = ST_LOCKED;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (scan_mode) begin
          state_d  = S_RESP;
          status_d = ST_SCAN;
        end else begin
          state_d = (READBACK_WAIT > 0) ? S_WAIT : S_CHECK;
        end
      end
      S_WAIT: begin
        if (scan_mode) begin
          state_d  = S_RESP;
          status_d = ST_SCAN;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (scan_mode) begin
          state_d  = S_RESP;
          status_d = ST_SCAN;
        end else if (readback != data_q) begin
          state_d  = S_RESP;
          status_d = ST_MISMATCH;
        end else if (lock_q) begin
          state_d = S_LOCK;
        end else begin
          state_d  = S_RESP;
          status_d = ST_OK;
        end
      end
      S_LOCK: begin
        state_d  = S_RESP;
        status_d = scan_mode ? ST_SCAN : ST_OK;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      data_q   <= '0;
      lock_q   <= 1'b0;
      cnt_q    <= '0;
      status_q <= ST_OK;
      shadow_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        addr_q <= req_addr;
        data_q <= req_data;
        lock_q <= req_lock;
      end
      if (state == S_WRITE)                 cnt_q <= 4'(READBACK_WAIT);
      else if (state == S_WAIT && cnt_q > 0) cnt_q <= cnt_q - 4'd1;
      status_q <= status_d;
      if (state == S_LOCK && !scan_mode) shadow_q <= shadow_q | addr_onehot;
    end
  end

  // req_ready is gated by resetn so it reads 0 for the whole reset window
  always_comb begin
    req_ready = resetn && (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    reg_write = (state == S_WRITE && !scan_mode) ? addr_onehot : '0;
    reg_lock  = (state == S_LOCK  && !scan_mode) ? addr_onehot : '0;
  end

endmodule

// File: tb/tb_locked_reg_programmer.sv
// tb/tb_locked_reg_programmer.sv - randomized bench with transaction-timeline model for locked_reg_programmer
module tb_locked_reg_programmer;
  localparam int W = 1;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        scan_mode;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [15:0] req_data;
  logic        req_lock;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [3:0]  reg_write;
  logic [15:0] reg_data_in;
  logic [3:0]  reg_lock;
  logic [63:0] reg_data_out;
  logic [3:0]  lock_shadow;

  locked_reg_programmer #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2), .READBACK_WAIT(W)) dut (
    .Clk(Clk), .resetn(resetn), .scan_mode(scan_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .reg_write(reg_write), .reg_data_in(reg_data_in), .reg_lock(reg_lock),
    .reg_data_out(reg_data_out), .lock_shadow(lock_shadow)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // bank model: stores written data, readback can be forced to zero per register
  logic [15:0] bank [4];
  logic [3:0]  force_mask = 4'b0;
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++) if (reg_write[i]) bank[i] <= reg_data_in;
  end
  always_comb begin
    reg_data_out = '0;
    for (int i = 0; i < 4; i++) reg_data_out[i*16 +: 16] = force_mask[i] ? 16'h0 : bank[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // transaction-timeline model: offset k counts cycles since the accept cycle
  localparam int M_IDLE = 0, M_OP = 1, M_RESP = 2;
  int          m_mode = M_IDLE;
  int          m_k = 0;
  logic [1:0]  m_status = 2'b00;
  logic [3:0]  m_shadow = 4'b0;
  logic [1:0]  t_addr = 2'b0;
  logic [15:0] t_data = 16'h0;
  logic        t_lock = 1'b0;

  int          acc_cnt = 0, acc_cyc = 0, rsp_cyc = 0, lock_cyc = 0, rsp_len = 0;
  int          write_pulses = 0, lock_pulses = 0;
  logic [3:0]  last_write_val = 4'b0, last_lock_val = 4'b0;
  logic [15:0] last_write_data = 16'h0;
  logic [1:0]  rsp_stat = 2'b0;
  logic        prev_valid = 1'b0;

  always @(negedge Clk) begin : monitor
    logic [3:0] oh, e_write, e_lock;
    logic [15:0] rb;
    if (!resetn) begin
      m_mode = M_IDLE; m_shadow = 4'b0; m_k = 0;
    end
    oh      = 4'b0001 << t_addr;
    e_write = (m_mode == M_OP && m_k == 1 && !scan_mode) ? oh : 4'b0;
    e_lock  = (m_mode == M_OP && m_k == W + 3 && !scan_mode) ? oh : 4'b0;
    chk("req_ready", {31'b0, req_ready}, {31'b0, resetn && m_mode == M_IDLE});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_mode == M_RESP});
    chk("reg_write", {28'b0, reg_write}, {28'b0, e_write});
    chk("reg_lock", {28'b0, reg_lock}, {28'b0, e_lock});
    chk("lock_shadow", {28'b0, lock_shadow}, {28'b0, m_shadow});
    if (!resetn) begin
      chk("reset_data_in", {16'b0, reg_data_in}, 32'h0);
      chk("reset_status", {30'b0, rsp_status}, 32'h0);
    end
    if (m_mode == M_OP && m_k <= W + 1) chk("reg_data_in", {16'b0, reg_data_in}, {16'b0, t_data});
    if (m_mode == M_RESP) chk("rsp_status", {30'b0, rsp_status}, {30'b0, m_status});

    if (reg_write != 0) begin
      write_pulses++; last_write_val = reg_write; last_write_data = reg_data_in;
    end
    if (reg_lock != 0) begin
      lock_pulses++; last_lock_val = reg_lock; lock_cyc = cyc;
    end
    if (rsp_valid && !prev_valid) begin
      rsp_cyc = cyc; rsp_stat = rsp_status; rsp_len = 0;
    end
    if (rsp_valid) rsp_len++;
    prev_valid = rsp_valid;

    if (resetn) begin
      case (m_mode)
        M_IDLE: if (req_valid) begin
          t_addr = req_addr; t_data = req_data; t_lock = req_lock;
          acc_cnt++; acc_cyc = cyc;
          if (scan_mode)                begin m_mode = M_RESP; m_status = 2'b11; end
          else if (m_shadow[req_addr])  begin m_mode = M_RESP; m_status = 2'b01; end
          else                          begin m_mode = M_OP;   m_k = 1; end
        end
        M_OP: begin
          rb = force_mask[t_addr] ? 16'h0 : t_data;
          if (scan_mode) begin m_mode = M_RESP; m_status = 2'b11; end
          else if (m_k == W + 2) begin
            if (rb != t_data)  begin m_mode = M_RESP; m_status = 2'b10; end
            else if (t_lock)   m_k++;
            else               begin m_mode = M_RESP; m_status = 2'b00; end
          end else if (m_k == W + 3) begin
            m_shadow[t_addr] = 1'b1; m_mode = M_RESP; m_status = 2'b00;
          end else m_k++;
        end
        default: if (rsp_ready) m_mode = M_IDLE;
      endcase
    end
  end

  task automatic send(input logic [1:0] a, input logic [15:0] d, input logic l, input int hold);
    int n;
    @(posedge Clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d; req_lock = l;
    n = 0;
    do begin @(negedge Clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin errors++; $display("FAIL accept_timeout"); end
    @(posedge Clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge Clk); n++; end
    if (!rsp_valid) begin errors++; $display("FAIL response_timeout"); end
    @(posedge Clk); #1;
    repeat (hold) begin @(posedge Clk); #1; end
    rsp_ready = 1'b1;
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic scan_after_accept(input int base, input int delay);
    int n = 0;
    while (acc_cnt == base && n < 60) begin @(negedge Clk); #1; n++; end
    repeat (delay) @(posedge Clk);
    #1 scan_mode = 1'b1;
  endtask

  int wp0, lp0, a0;

  initial begin
    resetn = 1'b0; scan_mode = 1'b0; req_valid = 1'b0; req_addr = 2'b0;
    req_data = 16'h0; req_lock = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_shadow", {28'b0, lock_shadow}, 32'h0);
    resetn = 1'b1;

    wp0 = write_pulses;
    send(2'd2, 16'hA5A5, 1'b0, 0);
    chk("t1_write_pulses", write_pulses - wp0, 1);
    chk("t1_write_val", {28'b0, last_write_val}, 32'h4);
    chk("t1_write_data", {16'b0, last_write_data}, 32'hA5A5);
    chk("t1_latency", rsp_cyc - acc_cyc, 4);
    chk("t1_status", {30'b0, rsp_stat}, 0);
    chk("t1_shadow", {28'b0, lock_shadow}, 0);

    send(2'd1, 16'h1234, 1'b1, 0);
    chk("t2_lock_at", lock_cyc - acc_cyc, 4);
    chk("t2_lock_val", {28'b0, last_lock_val}, 32'h2);
    chk("t2_latency", rsp_cyc - acc_cyc, 5);
    chk("t2_shadow", {28'b0, lock_shadow}, 32'h2);
    wp0 = write_pulses;
    send(2'd1, 16'h5555, 1'b0, 0);
    chk("t2_relock_status", {30'b0, rsp_stat}, 1);
    chk("t2_relock_latency", rsp_cyc - acc_cyc, 1);
    chk("t2_relock_no_write", write_pulses - wp0, 0);

    force_mask = 4'b1000;
    lp0 = lock_pulses;
    send(2'd3, 16'hFFFF, 1'b1, 0);
    force_mask = 4'b0000;
    chk("t3_status", {30'b0, rsp_stat}, 2);
    chk("t3_latency", rsp_cyc - acc_cyc, 4);
    chk("t3_no_lock", lock_pulses - lp0, 0);
    chk("t3_shadow", {28'b0, lock_shadow}, 32'h2);

    scan_mode = 1'b1;
    wp0 = write_pulses;
    send(2'd0, 16'h0F0F, 1'b0, 0);
    scan_mode = 1'b0;
    chk("t4_scan_status", {30'b0, rsp_stat}, 3);
    chk("t4_scan_latency", rsp_cyc - acc_cyc, 1);
    chk("t4_scan_no_write", write_pulses - wp0, 0);

    wp0 = write_pulses; lp0 = lock_pulses; a0 = acc_cnt;
    fork
      send(2'd2, 16'hBEEF, 1'b1, 0);
      scan_after_accept(a0, 2);
    join
    scan_mode = 1'b0;
    chk("t4_wait_abort_status", {30'b0, rsp_stat}, 3);
    chk("t4_wait_abort_latency", rsp_cyc - acc_cyc, 3);
    chk("t4_wait_abort_writes", write_pulses - wp0, 1);
    chk("t4_wait_abort_no_lock", lock_pulses - lp0, 0);
    chk("t4_wait_abort_shadow", {28'b0, lock_shadow}, 32'h2);

    @(posedge Clk); #1;
    req_valid = 1'b1; req_addr = 2'd2; req_data = 16'h1111; req_lock = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    @(posedge Clk); #1;
    resetn = 1'b0;
    #1;
    chk("t5_req_ready", {31'b0, req_ready}, 0);
    chk("t5_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("t5_reg_write", {28'b0, reg_write}, 0);
    chk("t5_reg_lock", {28'b0, reg_lock}, 0);
    chk("t5_data_in", {16'b0, reg_data_in}, 0);
    chk("t5_shadow", {28'b0, lock_shadow}, 0);
    @(posedge Clk); #1;
    resetn = 1'b1;

    send(2'd0, 16'h7777, 1'b0, 5);
    chk("t6_valid_cycles", rsp_len, 7);
    chk("t6_status", {30'b0, rsp_stat}, 0);

    for (int it = 0; it < 90; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(posedge Clk); #1 resetn = 1'b0;
        @(posedge Clk); #1 resetn = 1'b1;
      end
      force_mask = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
      scan_mode  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 6) == 0) begin
        a0 = acc_cnt;
        fork
          send(2'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
          scan_after_accept(a0, $urandom_range(1, 4));
        join
      end else begin
        send(2'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
      scan_mode  = 1'b0;
      force_mask = 4'b0;
    end

    repeat (2) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/locked_reg_programmer.md
Name: locked_reg_programmer

Overview:
- Initiator-side sequencer that programs a bank of lockable 16-bit configuration registers.
- Accepts one write request at a time over a valid/ready interface and drives the per-register write strobe and data.
- Reads the register back and compares it against the written value. Optionally pulses that register's Lock input.
- Keeps a shadow copy of every lock so that writes to locked registers are refused before they reach the bank. Refuses all writes while scan_mode is high.

Parameters:
- DATA_W, 16, width of each register and of the request data.
- NUM_REGS, 4, number of registers in the bank; must equal 2**ADDR_W.
- ADDR_W, 2, request address width.
- READBACK_WAIT, 1, number of wait cycles between the write strobe and the readback compare; range 0..15.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- scan_mode  input  1  test mode; when high, all requests are rejected and no strobes are issued.
- req_valid  input  1  request valid.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_W  target register index.
- req_data  input  DATA_W  value to write.
- req_lock  input  1  lock the register after a successful write.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed.
- rsp_status  output  2  00 OK, 01 LOCKED, 10 MISMATCH, 11 SCAN.
- reg_write  output  NUM_REGS  one-hot write strobe to the bank.
- reg_data_in  output  DATA_W  write data to the bank.
- reg_lock  output  NUM_REGS  one-hot Lock pulse to the bank.
- reg_data_out  input  NUM_REGS*DATA_W  readback; register i occupies bits [i*DATA_W +: DATA_W].
- lock_shadow  output  NUM_REGS  current lock state of each register as tracked by this block.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_status=00.
  - reg_write=0, reg_lock=0, reg_data_in=0, lock_shadow=0.
  - State = IDLE; the captured address, data and lock flag are cleared.
- Lock shadow:
  - lock_shadow bits are set only in LOCK.
  - They are cleared only by resetn; there is no other unlock path.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_addr, req_data and req_lock, then branch in this priority:
    - scan_mode=1 -> RESP, status 11.
    - lock_shadow[addr]=1 -> RESP, status 01.
    - otherwise -> WRITE.
- WRITE (1 cycle):
  - reg_write[addr]=1 and reg_data_in=captured data.
  - Next state is WAIT if READBACK_WAIT>0, else CHECK.
- WAIT:
  - A down-counter loaded with READBACK_WAIT runs; the block moves to CHECK when the counter reaches 1.
  - reg_data_in holds the captured data.
- CHECK (1 cycle):
  - Compare reg_data_out slice [addr] against the captured data.
  - Mismatch -> RESP, status 10, no lock.
  - Match with req_lock=1 -> LOCK.
  - Match with req_lock=0 -> RESP, status 00.
- LOCK (1 cycle):
  - reg_lock[addr]=1 and lock_shadow[addr]<=1.
  - Next state is RESP, status 00.
- RESP:
  - rsp_valid=1 with rsp_status stable; req_ready=0.
  - Return to IDLE on the cycle rsp_ready=1.
  - rsp_valid and req_ready are never high in the same cycle.
- Strobe rules:
  - reg_write and reg_lock are one-hot or zero.
  - Each is high for exactly one cycle per request.
  - They are never high in the same cycle.
- Latency from the accept cycle T, with W=READBACK_WAIT:
  - Rejects: rsp_valid at T+1.
  - Write without lock: strobe at T+1, CHECK at T+2+W, rsp_valid at T+3+W.
  - Write with lock: LOCK at T+3+W, rsp_valid at T+4+W.
- scan_mode rising while in WRITE, WAIT, CHECK or LOCK:
  - Abort to RESP with status 11.
  - No strobe is issued in the abort cycle.
  - No reg_lock pulse and no lock_shadow update occur.
- scan_mode in RESP or IDLE: status already latched in RESP is unchanged.
- Reset asserted mid-operation: all outputs return immediately to their reset values, and a pending response is discarded.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after the rsp_valid/rsp_ready handshake.

Test Plan:
- Write without lock: reset, then request addr=2, data=16'hA5A5, lock=0, with the bank model returning the written value -> reg_write=4'b0100 for exactly 1 cycle, reg_data_in=A5A5, rsp_status=00 at T+4 (W=1), lock_shadow=0000.
- Write with lock, then rewrite: request addr=1, data=16'h1234, lock=1 -> reg_lock=4'b0010 pulse at T+4 and lock_shadow=0010. A second request to addr=1 -> rsp_status=01 at T+1 with no reg_write pulse.
- Readback mismatch: bank model forces its readback to 16'h0000 while addr=3, data=16'hFFFF, lock=1 -> rsp_status=10, no reg_lock pulse, lock_shadow[3]=0.
- Scan rejection: scan_mode=1 at accept -> rsp_status=11 at T+1, no strobes. scan_mode rising during WAIT -> rsp_status=11, no reg_lock pulse, lock_shadow unchanged.
- Reset and backpressure: assert resetn=0 in WAIT -> all outputs and lock_shadow return to 0 immediately. Then hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_status stay stable and req_ready stays 0 until the handshake.
